ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage sitting directly downstream of the decode/execute pipeline register.
- Consumes the *_E control and operand signals and selects operands with M/W forwarding.
- Computes the ALU result, including an iterative 32-cycle MUL that stalls the front end.
- Registers everything into the execute/memory (EM) pipeline register it owns, whose outputs are the *_M ports.

Parameters:
- XLEN, 32, datapath width
- MUL_CYCLES, 32, shift-add iterations for MUL (must equal XLEN)

Ports:
- CLK  in  1  clock
- RST  in  1  reset; one clock; reset is synchronous and active-high
- SelWB_E  in  2  writeback select, passed through
- WEN_E  in  1  register write enable, active-low (1 = no write)
- Load_E  in  1  instruction is a load
- DRW_E  in  1  data read/write, passed through
- DREQ_E  in  1  data request, active-low
- RS1Used_E, RS2Used_E  in  1 each  source operand used
- Sel1_E  in  1  operand A select: 0 = rs1, 1 = PCADD4_E
- Sel2_E  in  3  operand B select: 0 = rs2, 1 = zeroExt, 2 = Iext, 3 = shamtExt, 4 = PCADD4, else 0
- ALUOP_E  in  4  ALU operation
- RA0_E, RA1_E, WA_E  in  5 each  source/destination register addresses
- DOUT0_E, DOUT1_E, PCADD4_E, zeroExt_E, Iext_E, shamtExt_E  in  32 each  operands
- WBDATA_W  in  32  writeback-stage data
- WA_W  in  5  writeback-stage destination
- WEN_W  in  1  writeback-stage write enable, active-low
- Stall_E  out  1  hold fetch/decode and the DE register; DE must not flush while this is 1
- SelWB_M, WEN_M, Load_M, DRW_M, DREQ_M  out  2/1/1/1/1  EM register control
- WA_M  out  5  EM destination
- ALUOUT_M, STDATA_M, PCADD4_M  out  32 each  EM data; STDATA_M is the forwarded rs2

Behaviour:
- Reset (RST high at a CLK edge):
  - WEN_M = 1, DREQ_M = 1; all other *_M = 0.
  - Multiplier FSM goes to IDLE; Stall_E = 0.
  - Reset overrides an in-flight MUL; the partial product is discarded.
- Forwarding (combinational), rs1 path:
  - Source = ALUOUT_M if RS1Used_E, RA0_E != 0, WEN_M == 0, Load_M == 0 and WA_M == RA0_E.
  - Else WBDATA_W if WEN_W == 0 and WA_W == RA0_E != 0.
  - Else DOUT0_E. M has priority over W.
  - rs2 path is identical using RA1_E/DOUT1_E; its result drives both operand B (when Sel2_E = 0) and STDATA_M.
  - Load-use from M is prevented upstream by the hazard unit; this block never forwards a load from M.
- ALUOP encoding (results 32-bit, wrap-around):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA, 8 ROR (all shift by B[4:0])
  - 9 SLT (signed, result 0/1), 10 SLTU, 11 PASSB, 12 MUL (low 32 bits of A*B)
  - 13-15 produce 0
- Single-cycle ops: the result is captured into the EM register at the next CLK edge; latency 1.
- MUL FSM:
  - IDLE: if ALUOP_E == MUL, Stall_E = 1 (combinational). At the edge, latch A and B, clear the accumulator, cnt = 0, go to BUSY, and load a bubble into EM (WEN_M = 1, DREQ_M = 1, Load_M = 0, other data 0).
  - BUSY: Stall_E = 1. Each edge: if B[0], acc += A; then A <<= 1, B >>= 1, cnt++. After MUL_CYCLES iterations go to DONE. EM receives a bubble every cycle.
  - DONE: Stall_E = 0. EM captures the MUL instruction with ALUOUT_M = acc and its control fields from the DE inputs; go to IDLE.
  - DE advances at this same edge, so a back-to-back MUL starts fresh from IDLE.
  - Total MUL occupancy in E: MUL_CYCLES + 2 cycles.
- Operands are captured at MUL start. Forwarded values valid at that cycle are used; later M/W changes are ignored.
- WA_E = 0 with WEN_E = 0 passes through unchanged; suppressing the r0 write is the regfile's job.

Decomposition:
- Package risc_pkg: ALUOP codes, Sel2 encodings, SelWB encodings, MUL FSM state enum.
- Sub-module iter_mul:
  - Start/done handshake with start, a, b in and busy, done, p out.
  - Owns the counter and accumulator.
- ex_stage owns forwarding, ALU and the EM register.

Test Plan:
- ADD, DOUT0 = 5, DOUT1 = 7, Sel2 = 0 -> ALUOUT_M = 12 one cycle later; WEN_M follows WEN_E.
- Back-to-back dependency: prior ADD writes r3 = 0x10 (in M); next SUB uses r3, DOUT0 stale = 0 -> operand A = 0x10. The same register pending in both M and W -> M value wins.
- SRA with DOUT0 = 0x80000000, shamtExt = 4 -> ALUOUT_M = 0xF8000000; ROR 0x00000001 by 1 -> 0x80000000.
- MUL 0xFFFFFFFF x 3 -> Stall_E high for exactly 33 cycles; 33 bubbles (WEN_M = 1) reach EM; then ALUOUT_M = 0xFFFFFFFD.
- RST asserted at BUSY cycle 10 of a MUL -> next cycle Stall_E = 0, WEN_M = 1, DREQ_M = 1, FSM in IDLE. A following ADD completes normally.
- Load in M targeting r4, E uses r4 while W holds r4 = 9 -> operand = 9 (M not forwarded because Load_M = 1).

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: shared ALU op codes, operand-B selects, writeback selects and multiplier FSM states
package risc_pkg;
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_ROR   = 4'd8;
  localparam logic [3:0] ALU_SLT   = 4'd9;
  localparam logic [3:0] ALU_SLTU  = 4'd10;
  localparam logic [3:0] ALU_PASSB = 4'd11;
  localparam logic [3:0] ALU_MUL   = 4'd12;
  localparam logic [2:0] SEL2_RS2   = 3'd0;
  localparam logic [2:0] SEL2_ZEXT  = 3'd1;
  localparam logic [2:0] SEL2_IEXT  = 3'd2;
  localparam logic [2:0] SEL2_SHAMT = 3'd3;
  localparam logic [2:0] SEL2_PC4   = 3'd4;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;
endpackage

// File: rtl/ex_stage_iter_mul.sv
// iter_mul: shift-add multiplier (start/a/b in, busy/done/p out), MUL_CYCLES iterations then one DONE cycle
module iter_mul
  import risc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] p
);
  localparam int CW = $clog2(MUL_CYCLES);
  mul_state_t state_q, state_d;
  logic [XLEN-1:0] a_q, b_q, acc_q;
  logic [CW-1:0] cnt_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: state_d = start ? MUL_BUSY : MUL_IDLE;
      MUL_BUSY: state_d = (cnt_q == CW'(MUL_CYCLES - 1)) ? MUL_DONE : MUL_BUSY;
      default:  state_d = MUL_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= MUL_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == MUL_IDLE && start) begin
        a_q   <= a;
        b_q   <= b;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == MUL_BUSY) begin
        acc_q <= b_q[0] ? acc_q + a_q : acc_q;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
  assign busy = state_q == MUL_BUSY;
  assign done = state_q == MUL_DONE;
  assign p    = acc_q;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage (*_E controls/operands, W-stage forwarding in) with M/W forwarding, ALU, iterative MUL stall and EM register (*_M out)
module ex_stage
  import risc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [1:0]      SelWB_E,
  input  logic            WEN_E,
  input  logic            Load_E,
  input  logic            DRW_E,
  input  logic            DREQ_E,
  input  logic            RS1Used_E,
  input  logic            RS2Used_E,
  input  logic            Sel1_E,
  input  logic [2:0]      Sel2_E,
  input  logic [3:0]      ALUOP_E,
  input  logic [4:0]      RA0_E,
  input  logic [4:0]      RA1_E,
  input  logic [4:0]      WA_E,
  input  logic [XLEN-1:0] DOUT0_E,
  input  logic [XLEN-1:0] DOUT1_E,
  input  logic [XLEN-1:0] PCADD4_E,
  input  logic [XLEN-1:0] zeroExt_E,
  input  logic [XLEN-1:0] Iext_E,
  input  logic [XLEN-1:0] shamtExt_E,
  input  logic [XLEN-1:0] WBDATA_W,
  input  logic [4:0]      WA_W,
  input  logic            WEN_W,
  output logic            Stall_E,
  output logic [1:0]      SelWB_M,
  output logic            WEN_M,
  output logic            Load_M,
  output logic            DRW_M,
  output logic            DREQ_M,
  output logic [4:0]      WA_M,
  output logic [XLEN-1:0] ALUOUT_M,
  output logic [XLEN-1:0] STDATA_M,
  output logic [XLEN-1:0] PCADD4_M
);
  logic [XLEN-1:0] rs1, rs2, opa, opb, mul_p, res;
  logic [4:0] sh;
  logic is_mul, mul_busy, mul_done;
  assign rs1 = (RS1Used_E && RA0_E != '0 && !WEN_M && !Load_M && WA_M == RA0_E) ? ALUOUT_M :
               (!WEN_W && WA_W == RA0_E && RA0_E != '0) ? WBDATA_W : DOUT0_E;
  assign rs2 = (RS2Used_E && RA1_E != '0 && !WEN_M && !Load_M && WA_M == RA1_E) ? ALUOUT_M :
               (!WEN_W && WA_W == RA1_E && RA1_E != '0) ? WBDATA_W : DOUT1_E;
  assign opa = Sel1_E ? PCADD4_E : rs1;
  assign opb = (Sel2_E == SEL2_RS2)   ? rs2 :
               (Sel2_E == SEL2_ZEXT)  ? zeroExt_E :
               (Sel2_E == SEL2_IEXT)  ? Iext_E :
               (Sel2_E == SEL2_SHAMT) ? shamtExt_E :
               (Sel2_E == SEL2_PC4)   ? PCADD4_E : '0;
  assign sh = opb[4:0];
  assign is_mul = ALUOP_E == ALU_MUL;
  iter_mul #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .CLK  (CLK),
    .RST  (RST),
    .start(is_mul),
    .a    (opa),
    .b    (opb),
    .busy (mul_busy),
    .done (mul_done),
    .p    (mul_p)
  );
  assign Stall_E = mul_busy | (is_mul & ~mul_done);
  always_comb begin
    res = '0;
    case (ALUOP_E)
      ALU_ADD:   res = opa + opb;
      ALU_SUB:   res = opa - opb;
      ALU_AND:   res = opa & opb;
      ALU_OR:    res = opa | opb;
      ALU_XOR:   res = opa ^ opb;
      ALU_SLL:   res = opa << sh;
      ALU_SRL:   res = opa >> sh;
      ALU_SRA:   res = $signed(opa) >>> sh;
      ALU_ROR:   res = (opa >> sh) | (opa << (XLEN - 32'(sh)));
      ALU_SLT:   res = XLEN'($signed(opa) < $signed(opb));
      ALU_SLTU:  res = XLEN'(opa < opb);
      ALU_PASSB: res = opb;
      ALU_MUL:   res = mul_p;
      default:   res = '0;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST || Stall_E) begin
      SelWB_M  <= '0;
      WEN_M    <= 1'b1;
      Load_M   <= 1'b0;
      DRW_M    <= 1'b0;
      DREQ_M   <= 1'b1;
      WA_M     <= '0;
      ALUOUT_M <= '0;
      STDATA_M <= '0;
      PCADD4_M <= '0;
    end else begin
      SelWB_M  <= SelWB_E;
      WEN_M    <= WEN_E;
      Load_M   <= Load_E;
      DRW_M    <= DRW_E;
      DREQ_M   <= DREQ_E;
      WA_M     <= WA_E;
      ALUOUT_M <= res;
      STDATA_M <= rs2;
      PCADD4_M <= PCADD4_E;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and randomized checks of ex_stage against a behavioural model
module tb_ex_stage;
  logic CLK = 0, RST;
  logic [1:0] SelWB_E;
  logic WEN_E, Load_E, DRW_E, DREQ_E, RS1Used_E, RS2Used_E, Sel1_E;
  logic [2:0] Sel2_E;
  logic [3:0] ALUOP_E;
  logic [4:0] RA0_E, RA1_E, WA_E, WA_W;
  logic [31:0] DOUT0_E, DOUT1_E, PCADD4_E, zeroExt_E, Iext_E, shamtExt_E, WBDATA_W;
  logic WEN_W;
  logic Stall_E, WEN_M, Load_M, DRW_M, DREQ_M;
  logic [1:0] SelWB_M;
  logic [4:0] WA_M;
  logic [31:0] ALUOUT_M, STDATA_M, PCADD4_M;
  ex_stage dut (
    .CLK(CLK), .RST(RST), .SelWB_E(SelWB_E), .WEN_E(WEN_E), .Load_E(Load_E), .DRW_E(DRW_E),
    .DREQ_E(DREQ_E), .RS1Used_E(RS1Used_E), .RS2Used_E(RS2Used_E), .Sel1_E(Sel1_E), .Sel2_E(Sel2_E),
    .ALUOP_E(ALUOP_E), .RA0_E(RA0_E), .RA1_E(RA1_E), .WA_E(WA_E), .DOUT0_E(DOUT0_E), .DOUT1_E(DOUT1_E),
    .PCADD4_E(PCADD4_E), .zeroExt_E(zeroExt_E), .Iext_E(Iext_E), .shamtExt_E(shamtExt_E),
    .WBDATA_W(WBDATA_W), .WA_W(WA_W), .WEN_W(WEN_W), .Stall_E(Stall_E), .SelWB_M(SelWB_M),
    .WEN_M(WEN_M), .Load_M(Load_M), .DRW_M(DRW_M), .DREQ_M(DREQ_M), .WA_M(WA_M),
    .ALUOUT_M(ALUOUT_M), .STDATA_M(STDATA_M), .PCADD4_M(PCADD4_M)
  );
  always #5 CLK = ~CLK;
  int checks = 0, passes = 0;
  logic last_stall;
  logic [1:0] m_selwb;
  logic m_wen, m_load, m_drw, m_dreq;
  logic [4:0] m_wa;
  logic [31:0] m_alu, m_st, m_pc, m_prod;
  int m_cnt;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  function automatic logic [31:0] m_fwd(input logic used, input logic [4:0] ra, input logic [31:0] d);
    if (used && ra != 0 && m_wen == 0 && m_load == 0 && m_wa == ra) return m_alu;
    if (WEN_W == 0 && WA_W == ra && ra != 0) return WBDATA_W;
    return d;
  endfunction
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] dbl;
    int s;
    s = int'(b[4:0]);
    dbl = {a, a};
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << s;
      6: return a >> s;
      7: return 32'($signed(a) >>> s);
      8: return dbl[31:0] >> s | (s == 0 ? 32'd0 : a << (32 - s));
      9: return {31'd0, $signed(a) < $signed(b)};
      10: return {31'd0, a < b};
      11: return b;
      default: return 0;
    endcase
  endfunction
  task automatic bubble();
    m_selwb = 0; m_wen = 1; m_load = 0; m_drw = 0; m_dreq = 1;
    m_wa = 0; m_alu = 0; m_st = 0; m_pc = 0;
  endtask
  task automatic step();
    logic [31:0] a, r2, b;
    logic es;
    #1;
    r2 = m_fwd(RS2Used_E, RA1_E, DOUT1_E);
    a = Sel1_E ? PCADD4_E : m_fwd(RS1Used_E, RA0_E, DOUT0_E);
    case (Sel2_E)
      0: b = r2;
      1: b = zeroExt_E;
      2: b = Iext_E;
      3: b = shamtExt_E;
      4: b = PCADD4_E;
      default: b = 0;
    endcase
    es = (m_cnt == 0 && ALUOP_E == 12) || (m_cnt >= 1 && m_cnt <= 32);
    chk("stall", {31'd0, Stall_E}, {31'd0, es});
    last_stall = Stall_E;
    @(posedge CLK);
    #1;
    if (RST) begin
      bubble();
      m_cnt = 0;
    end else if (es) begin
      if (m_cnt == 0) m_prod = a * b;
      m_cnt++;
      bubble();
    end else begin
      m_alu = (m_cnt == 33) ? m_prod : ref_alu(ALUOP_E, a, b);
      m_cnt = 0;
      m_selwb = SelWB_E; m_wen = WEN_E; m_load = Load_E; m_drw = DRW_E; m_dreq = DREQ_E;
      m_wa = WA_E; m_st = r2; m_pc = PCADD4_E;
    end
    chk("selwb", {30'd0, SelWB_M}, {30'd0, m_selwb});
    chk("wen", {31'd0, WEN_M}, {31'd0, m_wen});
    chk("load", {31'd0, Load_M}, {31'd0, m_load});
    chk("drw", {31'd0, DRW_M}, {31'd0, m_drw});
    chk("dreq", {31'd0, DREQ_M}, {31'd0, m_dreq});
    chk("wa", {27'd0, WA_M}, {27'd0, m_wa});
    chk("aluout", ALUOUT_M, m_alu);
    chk("stdata", STDATA_M, m_st);
    chk("pcadd4", PCADD4_M, m_pc);
  endtask
  task automatic clr();
    SelWB_E = 0; WEN_E = 1; Load_E = 0; DRW_E = 0; DREQ_E = 1; RS1Used_E = 0; RS2Used_E = 0;
    Sel1_E = 0; Sel2_E = 0; ALUOP_E = 0; RA0_E = 0; RA1_E = 0; WA_E = 0;
    DOUT0_E = 0; DOUT1_E = 0; PCADD4_E = 0; zeroExt_E = 0; Iext_E = 0; shamtExt_E = 0;
    WBDATA_W = 0; WA_W = 0; WEN_W = 1;
  endtask
  task automatic rand_w();
    WBDATA_W = $urandom; WA_W = 5'($urandom_range(0, 7)); WEN_W = 1'($urandom);
  endtask
  task automatic rand_e();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    if (op == 12 && $urandom_range(0, 3) != 0) op = 0;
    SelWB_E = 2'($urandom); WEN_E = 1'($urandom); Load_E = 1'($urandom); DRW_E = 1'($urandom);
    DREQ_E = 1'($urandom); RS1Used_E = 1'($urandom); RS2Used_E = 1'($urandom);
    Sel1_E = ($urandom_range(0, 5) == 0); Sel2_E = 3'($urandom_range(0, 6)); ALUOP_E = op;
    RA0_E = 5'($urandom_range(0, 7)); RA1_E = 5'($urandom_range(0, 7)); WA_E = 5'($urandom_range(0, 7));
    DOUT0_E = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
    DOUT1_E = $urandom; PCADD4_E = $urandom; zeroExt_E = $urandom_range(0, 40);
    Iext_E = $urandom; shamtExt_E = $urandom_range(0, 31);
  endtask
  initial begin
    int st, bub;
    clr();
    RST = 1;
    m_cnt = 0; m_prod = 0;
    bubble();
    step(); step();
    RST = 0;
    chk("rst_wen", {31'd0, WEN_M}, 32'd1);
    chk("rst_dreq", {31'd0, DREQ_M}, 32'd1);
    chk("rst_alu", ALUOUT_M, 32'd0);
    #1 chk("rst_stall", {31'd0, Stall_E}, 32'd0);
    WEN_E = 0; WA_E = 5; DOUT0_E = 5; DOUT1_E = 7; step();
    chk("add_5_7", ALUOUT_M, 32'd12);
    chk("add_wen", {31'd0, WEN_M}, 32'd0);
    clr(); WEN_E = 0; WA_E = 3; DOUT0_E = 32'h10; step();
    clr(); ALUOP_E = 1; RS1Used_E = 1; RA0_E = 3; DOUT0_E = 0; Sel2_E = 1; zeroExt_E = 1;
    WEN_W = 0; WA_W = 3; WBDATA_W = 32'h99; step();
    chk("fwd_m_over_w", ALUOUT_M, 32'hF);
    clr(); ALUOP_E = 7; DOUT0_E = 32'h8000_0000; Sel2_E = 3; shamtExt_E = 4; step();
    chk("sra", ALUOUT_M, 32'hF800_0000);
    clr(); ALUOP_E = 8; DOUT0_E = 1; Sel2_E = 1; zeroExt_E = 1; step();
    chk("ror", ALUOUT_M, 32'h8000_0000);
    clr(); Load_E = 1; WEN_E = 0; WA_E = 4; SelWB_E = 1; DOUT0_E = 32'h100; step();
    clr(); RS1Used_E = 1; RA0_E = 4; DOUT0_E = 32'h55; Sel2_E = 1; WEN_W = 0; WA_W = 4; WBDATA_W = 9; step();
    chk("load_no_fwd_m", ALUOUT_M, 32'd9);
    clr(); ALUOP_E = 12; WEN_E = 0; WA_E = 6; DOUT0_E = 32'hFFFF_FFFF; DOUT1_E = 3;
    st = 0; bub = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!last_stall) break;
      st++;
      if (WEN_M) bub++;
    end
    chk("mul_stall_cycles", st, 33);
    chk("mul_bubbles", bub, 33);
    chk("mul_result", ALUOUT_M, 32'hFFFF_FFFD);
    chk("mul_wen", {31'd0, WEN_M}, 32'd0);
    clr(); ALUOP_E = 12; WEN_E = 0; DOUT0_E = 7; DOUT1_E = 9; step();
    for (int i = 0; i < 9; i++) step();
    RST = 1; ALUOP_E = 0; DOUT0_E = 2; DOUT1_E = 3; step();
    RST = 0;
    #1 chk("rst_mid_mul_stall", {31'd0, Stall_E}, 32'd0);
    chk("rst_mid_mul_wen", {31'd0, WEN_M}, 32'd1);
    chk("rst_mid_mul_dreq", {31'd0, DREQ_M}, 32'd1);
    step();
    chk("add_after_rst", ALUOUT_M, 32'd5);
    last_stall = 0;
    for (int i = 0; i < 2500; i++) begin
      if (!last_stall) rand_e();
      rand_w();
      RST = ($urandom_range(0, 199) == 0);
      step();
    end
    RST = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
